alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of clock cycles the ALU operands are held stable before the result is captured; the legal range is 1..15.
REQ-002 The module SHALL take operand and result widths from `W_CPU` and opcode width from `W_OPCODE` in lib/opcodes.v.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0_valid  in  1  port 0 request pending.
REQ-006 req0_ready  out  1  port 0 request accepted this cycle when high with req0_valid.
REQ-007 req0_op / req0_a / req0_b  in  `W_OPCODE / `W_CPU / `W_CPU  port 0 opcode, Rs operand, Rt operand.
REQ-008 resp0_valid  out  1  port 0 result available.
REQ-009 resp0_ready  in  1  port 0 consumes result.
REQ-010 resp0_r / resp0_ovf / resp0_zero  out  `W_CPU / 1 / 1  port 0 result, overflow, isZero flag.
REQ-011 req1_* / resp1_*  SHALL be identical to port 0 in direction, width and meaning, for port 1.
REQ-012 alu_op / alu_a / alu_b  out  `W_OPCODE / `W_CPU / `W_CPU  drive the shared ALU.
REQ-013 alu_r / alu_ovf / alu_zero  in  `W_CPU / 1 / 1  ALU result, overflow, isZero.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SETTLE and RESP.
REQ-016 In IDLE the grant SHALL go to the sole valid port, or on a tie to the port not equal to last_served.
REQ-017 reqK_ready SHALL be 1 only in IDLE for the granted port, and 0 in all other states.
REQ-018 On the accept edge (IDLE, reqK_valid && reqK_ready), the block SHALL register op/a/b, set owner=K, clear the settle counter and enter SETTLE.
REQ-019 alu_op, alu_a and alu_b SHALL be driven only from the registered copies, and SHALL remain stable from the accept edge until the next accept edge.
REQ-020 In SETTLE the counter SHALL increment each cycle.
REQ-021 On the edge where counter == SETTLE_CYCLES-1, the block SHALL capture alu_r, alu_ovf and alu_zero into the result registers and enter RESP.
REQ-022 respK_valid SHALL assert exactly SETTLE_CYCLES cycles after the accept edge, for owner K only.
REQ-023 The result registers and respK_valid SHALL hold unchanged in RESP until respK_ready is sampled high; no timeout SHALL apply.
REQ-024 On the response handshake edge the block SHALL set last_served=owner, deassert respK_valid and return to IDLE.
REQ-025 No request SHALL be accepted on the response handshake edge; minimum issue spacing is therefore SETTLE_CYCLES+2 cycles.
REQ-026 respK_r, respK_ovf and respK_zero SHALL show the captured values while respK_valid is high.
REQ-027 resp outputs of the non-owner port SHALL be zero.
REQ-028 The block SHALL NOT modify or interpret opcodes, and SHALL pass SLL, SRL, SLT and all other opcodes unchanged.
REQ-029 A change on reqK_op/a/b after acceptance SHALL have no effect on the in-flight operation.
REQ-030 A request dropped before acceptance SHALL be ignored, with no state change.
REQ-031 An assertion of respK_ready with respK_valid low SHALL be ignored.

Reset
REQ-032 rst high at a clock edge SHALL force IDLE, counter=0, last_served=1 (port 0 wins the first tie), owner=0, all registered op/a/b/result values=0, and all ready/valid outputs=0.
REQ-033 busy SHALL be 0 during reset.
REQ-034 rst asserted in SETTLE or RESP SHALL abort the in-flight operation, and no response for it SHALL ever be produced.
REQ-035 rst SHALL take priority over every handshake in the same cycle.

Verification
REQ-036 The bench SHALL cover: SETTLE_CYCLES=2, port 0 issues `F_ADD with a=5, b=7, resp0_ready held 1 -> resp0_valid high 2 cycles after accept, resp0_r=12, resp0_ovf=0, and resp1_valid=0 throughout.
REQ-037 The bench SHALL cover: both ports request simultaneously after reset, both issuing `F_SUB with a=9, b=4 -> port 0 served first (r=5), then port 1; a second simultaneous tie -> port 0 served first again, because last_served=1 after port 1 completes.
REQ-038 The bench SHALL cover: port 1 requests continuously while port 0 requests once -> the grant alternates, and port 0 is accepted no later than the second IDLE after its valid rises.
REQ-039 The bench SHALL cover: resp0_ready held 0 for 10 cycles -> resp0_valid and resp0_r stay constant, busy=1, req1_ready stays 0, and completion occurs on the cycle resp0_ready rises.
REQ-040 The bench SHALL cover: rst pulsed one cycle during SETTLE -> next cycle all outputs are at reset values, no resp_valid ever appears for the aborted operation, and a new `F_OR with a=0xF0, b=0x0F then completes with r=0xFF.
REQ-041 The bench SHALL cover: req0_a is changed from 3 to 100 during SETTLE of `F_ADD with a=3, b=1 -> alu_a stays 3, and resp0_r=4.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: it grants one request,
// holds operands stable for SETTLE_CYCLES, captures the result, and returns it to the owner.
`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_OPCODE
`define W_OPCODE 6
`endif

module alu_arbiter #(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [`W_OPCODE-1:0] req0_op,
  input  logic [`W_CPU-1:0]    req0_a,
  input  logic [`W_CPU-1:0]    req0_b,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic [`W_CPU-1:0]    resp0_r,
  output logic                 resp0_ovf,
  output logic                 resp0_zero,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [`W_OPCODE-1:0] req1_op,
  input  logic [`W_CPU-1:0]    req1_a,
  input  logic [`W_CPU-1:0]    req1_b,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [`W_CPU-1:0]    resp1_r,
  output logic                 resp1_ovf,
  output logic                 resp1_zero,
  output logic [`W_OPCODE-1:0] alu_op,
  output logic [`W_CPU-1:0]    alu_a,
  output logic [`W_CPU-1:0]    alu_b,
  input  logic [`W_CPU-1:0]    alu_r,
  input  logic                 alu_ovf,
  input  logic                 alu_zero,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  typedef struct packed {
    logic [`W_OPCODE-1:0] op;
    logic [`W_CPU-1:0]    a;
    logic [`W_CPU-1:0]    b;
  } req_t;
  typedef struct packed {
    logic [`W_CPU-1:0] r;
    logic              ovf;
    logic              zero;
  } resp_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       owner, last_served;
  logic       gnt, gnt_vld, accept, done, settled;
  req_t       op_q, req_sel;
  resp_t      res_q;
  logic [1:0] req_valid, resp_ready, resp_valid;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req_sel    = gnt ? {req1_op, req1_a, req1_b} : {req0_op, req0_a, req0_b};

  // On a tie the port that was not served last wins; last_served resets to 1.
  always_comb begin
    gnt_vld = |req_valid;
    gnt     = 1'b0;
    case (req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_served;
      default: gnt = 1'b0;
    endcase
  end

  // Reset overrides every handshake, so gate both with rst.
  assign accept  = !rst && (state == IDLE) && gnt_vld;
  assign done    = !rst && (state == RESP) && resp_ready[owner];
  assign settled = (state == SETTLE) && (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = SETTLE;
      SETTLE:  if (settled) state_nxt = RESP;
      RESP:    if (done)    state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      op_q        <= '0;
      res_q       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= req_sel;
        owner <= gnt;
        cnt   <= '0;
      end
      if (state == SETTLE) cnt <= cnt + 4'd1;
      if (settled) res_q <= {alu_r, alu_ovf, alu_zero};
      if (done) last_served <= owner;
    end
  end

  assign alu_op = op_q.op;
  assign alu_a  = op_q.a;
  assign alu_b  = op_q.b;

  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;
  assign resp_valid = {2{!rst && (state == RESP)}} & {owner, !owner};
  assign busy       = !rst && (state != IDLE);

  assign resp0_valid = resp_valid[0];
  assign resp0_r     = resp_valid[0] ? res_q.r : '0;
  assign resp0_ovf   = resp_valid[0] & res_q.ovf;
  assign resp0_zero  = resp_valid[0] & res_q.zero;
  assign resp1_valid = resp_valid[1];
  assign resp1_r     = resp_valid[1] ? res_q.r : '0;
  assign resp1_ovf   = resp_valid[1] & res_q.ovf;
  assign resp1_zero  = resp_valid[1] & res_q.zero;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: the bench owns the shared ALU and predicts grants,
// latency and results from the arbitration rules and plain arithmetic.
`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_OPCODE
`define W_OPCODE 6
`endif
`ifndef F_ADD
`define F_ADD 'h20
`define F_SUB 'h22
`define F_AND 'h24
`define F_OR  'h25
`define F_XOR 'h26
`define F_SLT 'h2a
`define F_SLL 'h00
`define F_SRL 'h02
`endif

module tb_alu_arbiter;
  localparam int W = `W_CPU;
  localparam int OPW = `W_OPCODE;
  localparam int SC = 2;
  localparam logic [OPW-1:0] OP_ADD = OPW'(`F_ADD);
  localparam logic [OPW-1:0] OP_SUB = OPW'(`F_SUB);
  localparam logic [OPW-1:0] OP_AND = OPW'(`F_AND);
  localparam logic [OPW-1:0] OP_OR  = OPW'(`F_OR);
  localparam logic [OPW-1:0] OP_XOR = OPW'(`F_XOR);
  localparam logic [OPW-1:0] OP_SLT = OPW'(`F_SLT);
  localparam logic [OPW-1:0] OP_SLL = OPW'(`F_SLL);
  localparam logic [OPW-1:0] OP_SRL = OPW'(`F_SRL);

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_ovf, resp0_zero;
  logic req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_ovf, resp1_zero;
  logic [OPW-1:0] req0_op, req1_op, alu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, resp0_r, resp1_r, alu_a, alu_b, alu_r;
  logic alu_ovf, alu_zero, busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_r(resp0_r), .resp0_ovf(resp0_ovf), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_r(resp1_r), .resp1_ovf(resp1_ovf), .resp1_zero(resp1_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .busy(busy)
  );

  function automatic logic [W-1:0] ref_r(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      OP_SLL:  return b << a[4:0];
      OP_SRL:  return b >> a[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    s = ref_r(op, a, b);
    if (op == OP_ADD) return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    if (op == OP_SUB) return (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    return 1'b0;
  endfunction

  // Shared ALU, owned by the bench.
  always_comb begin
    alu_r    = ref_r(alu_op, alu_a, alu_b);
    alu_ovf  = ref_ovf(alu_op, alu_a, alu_b);
    alu_zero = (ref_r(alu_op, alu_a, alu_b) == '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0; resp0_ready = 0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0; resp1_ready = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
  endtask

  // Waits (bounded) for port p's response; reports latency, captured values, and
  // whether the other port's resp_valid ever rose meanwhile.
  task automatic run_to_resp(input int p, output bit to, output bit wrong, output int lat,
                             output logic [W-1:0] r, output logic ovf, output logic zero);
    to = 1; wrong = 0; lat = 0; r = '0; ovf = 0; zero = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if ((p == 0) ? resp1_valid : resp0_valid) wrong = 1;
      if ((p == 0) ? resp0_valid : resp1_valid) begin
        to = 0; lat = i;
        r    = (p == 0) ? resp0_r : resp1_r;
        ovf  = (p == 0) ? resp0_ovf : resp1_ovf;
        zero = (p == 0) ? resp0_zero : resp1_zero;
        return;
      end
    end
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1; req0_valid = 1; req1_valid = 1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b exp 0", req1_ready); end
    checks++; if ({resp0_valid, resp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b exp 00", {resp0_valid, resp1_valid}); end
    checks++; if ({alu_op, alu_a, alu_b} !== '0) begin errors++; $display("FAIL reset_alu_regs: got %0h/%0h/%0h exp 0", alu_op, alu_a, alu_b); end
    rst = 0; req1_valid = 0;
    #1;
    // Port 0 must win the first tie-free request after reset and be ready immediately.
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_first_grant: got %b exp 1", req0_ready); end
    do_reset();
  endtask

  task automatic test_single_add();
    bit to, wrong; int lat; logic [W-1:0] r; logic ovf, zero;
    do_reset();
    resp0_ready = 1; resp1_ready = 1;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 5; req0_b = 7;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b exp 1", req0_ready); end
    step();
    req0_valid = 0;
    run_to_resp(0, to, wrong, lat, r, ovf, zero);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL add_timeout: no resp0_valid within bound"); end
    checks++; if (wrong !== 1'b0) begin errors++; $display("FAIL add_resp1_valid: got 1 exp 0"); end
    checks++; if (lat != SC) begin errors++; $display("FAIL add_latency: got %0d exp %0d", lat, SC); end
    checks++; if ({r, ovf, zero} !== {W'(12), 1'b0, 1'b0}) begin errors++; $display("FAIL add_result: got r=%0d ovf=%b z=%b exp r=12 ovf=0 z=0", r, ovf, zero); end
    step();
    checks++; if ({resp0_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_complete: got valid=%b busy=%b exp 0/0", resp0_valid, busy); end
  endtask

  task automatic test_tie();
    bit to, wrong; int lat; logic [W-1:0] r; logic ovf, zero;
    do_reset();
    resp0_ready = 1; resp1_ready = 1;
    for (int round = 0; round < 2; round++) begin
      req0_valid = 1; req0_op = OP_SUB; req0_a = 9; req0_b = 4;
      req1_valid = 1; req1_op = OP_SUB; req1_a = 9; req1_b = 4;
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL tie%0d_grant0: got ready1/0=%b exp 01", round, {req1_ready, req0_ready}); end
      step();
      req0_valid = 0;
      run_to_resp(0, to, wrong, lat, r, ovf, zero);
      checks++; if (to || wrong || lat != SC || r !== W'(5)) begin errors++; $display("FAIL tie%0d_port0: got to=%b wrong=%b lat=%0d r=%0d exp 0/0/%0d/5", round, to, wrong, lat, r, SC); end
      step();
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL tie%0d_grant1: got %b exp 1", round, req1_ready); end
      step();
      req1_valid = 0;
      run_to_resp(1, to, wrong, lat, r, ovf, zero);
      checks++; if (to || wrong || lat != SC || r !== W'(5)) begin errors++; $display("FAIL tie%0d_port1: got to=%b wrong=%b lat=%0d r=%0d exp 0/0/%0d/5", round, to, wrong, lat, r, SC); end
      step();
    end
  endtask

  task automatic test_alternate();
    int order[$]; int idles = 0; int n0 = 0; bit acc0;
    do_reset();
    resp0_ready = 1; resp1_ready = 1;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 1; req1_b = 2;
    for (int c = 0; c < 60; c++) begin
      if (c == 3) begin req0_valid = 1; req0_op = OP_XOR; req0_a = 6; req0_b = 3; end
      #1;
      acc0 = 0;
      if (req0_valid && !busy) idles++;
      if (req0_valid && req0_ready) begin
        acc0 = 1; n0++; order.push_back(0);
        checks++; if (idles > 2) begin errors++; $display("FAIL alt_starve: port0 accepted at idle %0d exp <=2", idles); end
      end
      if (req1_valid && req1_ready) order.push_back(1);
      step();
      if (acc0) req0_valid = 0;
    end
    checks++; if (n0 != 1) begin errors++; $display("FAIL alt_port0_count: got %0d exp 1", n0); end
    checks++; if (order.size() < 3) begin errors++; $display("FAIL alt_accepts: got %0d exp >=3", order.size()); end
    else begin
      checks++; if ({order[0], order[1], order[2]} !== {32'd1, 32'd0, 32'd1}) begin errors++; $display("FAIL alt_order: got %0d,%0d,%0d exp 1,0,1", order[0], order[1], order[2]); end
    end
    req1_valid = 0;
    for (int i = 0; i < 20 && busy; i++) step();
  endtask

  task automatic test_backpressure();
    bit to, wrong; int lat; logic [W-1:0] r, exp_r; logic ovf, zero;
    do_reset();
    resp0_ready = 0; resp1_ready = 1;
    req0_valid = 1; req0_op = OP_AND; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1; req1_op = OP_OR; req1_a = $urandom; req1_b = $urandom;
    exp_r = ref_r(OP_AND, req0_a, req0_b);
    #1;
    step();
    req0_valid = 0;
    run_to_resp(0, to, wrong, lat, r, ovf, zero);
    checks++; if (to || lat != SC || r !== exp_r) begin errors++; $display("FAIL bp_first: got to=%b lat=%0d r=%0h exp 0/%0d/%0h", to, lat, r, SC, exp_r); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if ({resp0_valid, busy, req1_ready} !== 3'b110 || resp0_r !== exp_r) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b busy=%b rdy1=%b r=%0h exp 1/1/0/%0h", i, resp0_valid, busy, req1_ready, resp0_r, exp_r);
      end
    end
    resp0_ready = 1;
    step();
    checks++; if ({resp0_valid, req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got valid0=%b rdy1=%b exp 0/1", resp0_valid, req1_ready); end
    exp_r = ref_r(OP_OR, req1_a, req1_b);
    step();
    req1_valid = 0;
    run_to_resp(1, to, wrong, lat, r, ovf, zero);
    checks++; if (to || wrong || r !== exp_r) begin errors++; $display("FAIL bp_port1: got to=%b wrong=%b r=%0h exp 0/0/%0h", to, wrong, r, exp_r); end
    step();
  endtask

  task automatic test_reset_abort();
    bit to, wrong, seen; int lat; logic [W-1:0] r; logic ovf, zero;
    do_reset();
    resp0_ready = 1; resp1_ready = 1;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 11; req0_b = 22;
    #1;
    step();
    req0_valid = 0;
    step();
    rst = 1; req1_valid = 1;
    #1;
    checks++; if ({busy, req1_ready, resp0_valid} !== 3'b000) begin errors++; $display("FAIL abort_during: got busy=%b rdy1=%b valid0=%b exp 000", busy, req1_ready, resp0_valid); end
    step();
    rst = 0; req1_valid = 0;
    #1;
    checks++; if ({busy, resp0_valid, resp1_valid, req0_ready, req1_ready} !== 5'b0 || {alu_op, alu_a, alu_b} !== '0 || resp0_r !== '0) begin
      errors++; $display("FAIL abort_after: got busy=%b v0=%b v1=%b alu=%0h/%0h/%0h r0=%0h exp all 0", busy, resp0_valid, resp1_valid, alu_op, alu_a, alu_b, resp0_r);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin step(); if (resp0_valid || resp1_valid) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_ghost_resp: got 1 exp 0"); end
    req0_valid = 1; req0_op = OP_OR; req0_a = 'hF0; req0_b = 'h0F;
    #1;
    step();
    req0_valid = 0;
    run_to_resp(0, to, wrong, lat, r, ovf, zero);
    checks++; if (to || lat != SC || r !== W'('hFF)) begin errors++; $display("FAIL abort_or: got to=%b lat=%0d r=%0h exp 0/%0d/ff", to, lat, r, SC); end
    step();
  endtask

  task automatic test_operand_change();
    bit to, wrong; int lat; logic [W-1:0] r; logic ovf, zero;
    do_reset();
    resp0_ready = 1;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 3; req0_b = 1;
    #1;
    step();
    req0_valid = 0; req0_a = 100;
    #1;
    checks++; if (alu_a !== W'(3)) begin errors++; $display("FAIL opchg_alu_a: got %0d exp 3", alu_a); end
    run_to_resp(0, to, wrong, lat, r, ovf, zero);
    checks++; if (alu_a !== W'(3)) begin errors++; $display("FAIL opchg_alu_a_late: got %0d exp 3", alu_a); end
    checks++; if (to || r !== W'(4)) begin errors++; $display("FAIL opchg_result: got to=%b r=%0d exp 0/4", to, r); end
    step();
  endtask

  task automatic test_random();
    logic [OPW-1:0] ops [8];
    logic [OPW-1:0] rop [2];
    logic [W-1:0] ra [2], rb [2];
    logic [W-1:0] r, exp_r; logic ovf, zero;
    bit to, wrong; int lat, mask, ep, last;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL};
    do_reset();
    last = 1;
    for (int n = 0; n < 40; n++) begin
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        rop[p] = ops[$urandom_range(0, 7)];
        ra[p] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
        rb[p] = ($urandom_range(0, 3) == 0) ? ra[p] : W'($urandom);
      end
      req0_valid = mask[0]; req0_op = rop[0]; req0_a = ra[0]; req0_b = rb[0];
      req1_valid = mask[1]; req1_op = rop[1]; req1_a = ra[1]; req1_b = rb[1];
      ep = (mask == 1) ? 0 : (mask == 2) ? 1 : (last == 1) ? 0 : 1;
      #1;
      checks++; if ({req1_ready, req0_ready} !== ((ep == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rnd%0d_grant: got ready1/0=%b exp port %0d", n, {req1_ready, req0_ready}, ep); end
      step();
      req0_valid = 0; req1_valid = 0;
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      exp_r = ref_r(rop[ep], ra[ep], rb[ep]);
      run_to_resp(ep, to, wrong, lat, r, ovf, zero);
      checks++; if (to || wrong || lat != SC || r !== exp_r || ovf !== ref_ovf(rop[ep], ra[ep], rb[ep]) || zero !== (exp_r == '0)) begin
        errors++; $display("FAIL rnd%0d_resp: port %0d op %0h got to=%b wrong=%b lat=%0d r=%0h ovf=%b z=%b exp r=%0h ovf=%b z=%b", n, ep, rop[ep], to, wrong, lat, r, ovf, zero, exp_r, ref_ovf(rop[ep], ra[ep], rb[ep]), exp_r == '0);
      end
      repeat ($urandom_range(0, 3)) step();
      if (ep == 0) resp0_ready = 1; else resp1_ready = 1;
      step();
      resp0_ready = 0; resp1_ready = 0;
      last = ep;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: busy got %b exp 0", n, busy); end
    end
  endtask

  initial begin
    rst = 1;
    clr_inputs();
    test_reset();
    test_single_add();
    test_tie();
    test_alternate();
    test_backpressure();
    test_reset_abort();
    test_operand_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
